// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared state encodings and helpers for the equivalence-check sequencer
package equiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when the low 'width' bits of 'bits' are all 0 or all 1.
  function automatic logic all_equal(input logic [31:0] bits, input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return ((bits & mask) == 32'd0) || ((bits & mask) == mask);
  endfunction

endpackage

// File: rtl/equiv_settle_timer.sv
// rtl/equiv_settle_timer.sv - per-vector settle counter; expired marks the last held cycle
module equiv_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == 8'(SETTLE - 1));

endmodule

// File: rtl/equiv_check_sequencer.sv
// rtl/equiv_check_sequencer.sv - sweeps every input vector and checks all implementation outputs agree
module equiv_check_sequencer
  import equiv_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_IMPL = 3,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_IMPL-1:0] impl_out,
  output logic [N_IN-1:0]   vec_out,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_count,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic              first_fail_valid
);

  localparam logic [N_IN-1:0] VEC_MAX = '1;
  localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
  localparam logic [N_IN:0]   MC_ONE  = (N_IN + 1)'(1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_out_q, vec_out_d;
  logic              vec_valid_q, vec_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     mismatch_count_q, mismatch_count_d;
  logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;
  logic              first_fail_valid_q, first_fail_valid_d;
  logic              clear_results;
  logic              expired;
  logic              mismatch;

  assign mismatch = (impl_out != '0) && (impl_out != '1);

  equiv_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_q != ST_APPLY) || expired),
    .en     (state_q == ST_APPLY),
    .expired(expired)
  );

  always_comb begin
    state_d            = state_q;
    vec_out_d          = vec_out_q;
    done_d             = done_q;
    pass_d             = pass_q;
    mismatch_count_d   = mismatch_count_q;
    first_fail_vec_d   = first_fail_vec_q;
    first_fail_valid_d = first_fail_valid_q;
    clear_results      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d       = ST_APPLY;
          clear_results = 1'b1;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d       = ST_IDLE;
          clear_results = 1'b1;
        end else if (expired) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d       = ST_IDLE;
          clear_results = 1'b1;
        end else begin
          if (mismatch) begin
            mismatch_count_d = mismatch_count_q + MC_ONE;
            if (!first_fail_valid_q) begin
              first_fail_vec_d   = vec_out_q;
              first_fail_valid_d = 1'b1;
            end
          end
          // Terminal compare comes first so vec_out never wraps past the last vector.
          if (vec_out_q == VEC_MAX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (mismatch_count_d == '0);
          end else begin
            vec_out_d = vec_out_q + VEC_ONE;
            state_d   = ST_APPLY;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d       = abort ? ST_IDLE : ST_APPLY;
          clear_results = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        clear_results = 1'b1;
      end
    endcase

    if (clear_results) begin
      vec_out_d          = '0;
      done_d             = 1'b0;
      pass_d             = 1'b0;
      mismatch_count_d   = '0;
      first_fail_vec_d   = '0;
      first_fail_valid_d = 1'b0;
    end

    busy_d      = (state_d == ST_APPLY) || (state_d == ST_CHECK);
    vec_valid_d = busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      vec_out_q          <= '0;
      vec_valid_q        <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      mismatch_count_q   <= '0;
      first_fail_vec_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      vec_out_q          <= vec_out_d;
      vec_valid_q        <= vec_valid_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
      mismatch_count_q   <= mismatch_count_d;
      first_fail_vec_q   <= first_fail_vec_d;
      first_fail_valid_q <= first_fail_valid_d;
    end
  end

  assign vec_out          = vec_out_q;
  assign vec_valid        = vec_valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mismatch_count_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// tb/tb_equiv_check_sequencer.sv - directed bench for two sequencers (SETTLE=1 and SETTLE=3)
module tb_equiv_check_sequencer;
  import equiv_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] mask;
  logic       chk_en;

  logic [2:0] impl_i    [2];
  logic [2:0] vec_o     [2];
  logic       vv_o      [2];
  logic       busy_o    [2];
  logic       done_o    [2];
  logic       pass_o    [2];
  logic [3:0] mc_o      [2];
  logic [2:0] ffv_o     [2];
  logic       ffvalid_o [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  equiv_check_sequencer #(.N_IN(3), .N_IMPL(3), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .impl_out(impl_i[0]),
    .vec_out(vec_o[0]), .vec_valid(vv_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .mismatch_count(mc_o[0]), .first_fail_vec(ffv_o[0]),
    .first_fail_valid(ffvalid_o[0])
  );

  equiv_check_sequencer #(.N_IN(3), .N_IMPL(3), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .impl_out(impl_i[1]),
    .vec_out(vec_o[1]), .vec_valid(vv_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .mismatch_count(mc_o[1]), .first_fail_vec(ffv_o[1]),
    .first_fail_valid(ffvalid_o[1])
  );

  // Implementations under test: parity of the vector, or a disagreeing pattern where mask says so.
  function automatic logic [2:0] pattern(input logic [2:0] v, input logic [7:0] m);
    if (m[v]) return v[0] ? 3'b101 : 3'b010;
    return {3{^v}};
  endfunction

  assign impl_i[0] = pattern(vec_o[0], mask);
  assign impl_i[1] = pattern(vec_o[1], mask);

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is just a cycle count k since the accept edge; vector v is judged
  // at the edge k = (v+1)*(S+1), so results are whatever failing vectors lie behind k.
  int         m_st   [2];
  int         m_k    [2];
  logic [7:0] m_mask [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_st[i] <= 0;
      end else begin
        case (m_st[i])
          0: if (start && !abort) begin
               m_st[i] <= 1; m_k[i] <= 0; m_mask[i] <= mask;
             end
          1: if (abort) m_st[i] <= 0;
             else begin
               m_k[i] <= m_k[i] + 1;
               if (m_k[i] + 1 == 8 * (settle_of(i) + 1)) m_st[i] <= 2;
             end
          default: if (start) begin
               if (abort) m_st[i] <= 0;
               else begin m_st[i] <= 1; m_k[i] <= 0; m_mask[i] <= mask; end
             end
        endcase
      end
    end
  end

  function automatic void model_counts(input int s, input int k, input logic [7:0] m,
                                       output int mc, output int ffvalid, output int ffv);
    mc = 0; ffvalid = 0; ffv = 0;
    for (int v = 0; v < 8; v++) begin
      if ((v + 1) * (s + 1) <= k && !all_equal(32'(pattern(3'(v), m)), 3)) begin
        if (mc == 0) begin ffvalid = 1; ffv = v; end
        mc++;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int s, e_vec, e_act, e_done, e_pass, e_mc, e_ffvalid, e_ffv;
        s = settle_of(i);
        e_vec = 0; e_act = 0; e_done = 0; e_pass = 0; e_mc = 0; e_ffvalid = 0; e_ffv = 0;
        if (m_st[i] == 1) begin
          e_vec = m_k[i] / (s + 1);
          e_act = 1;
          model_counts(s, m_k[i], m_mask[i], e_mc, e_ffvalid, e_ffv);
        end else if (m_st[i] == 2) begin
          e_vec = 7;
          e_done = 1;
          model_counts(s, 8 * (s + 1), m_mask[i], e_mc, e_ffvalid, e_ffv);
          e_pass = (e_mc == 0) ? 1 : 0;
        end
        chk($sformatf("d%0d_vec_out", i), 32'(vec_o[i]), 32'(e_vec));
        chk($sformatf("d%0d_vec_valid", i), 32'(vv_o[i]), 32'(e_act));
        chk($sformatf("d%0d_busy", i), 32'(busy_o[i]), 32'(e_act));
        chk($sformatf("d%0d_done", i), 32'(done_o[i]), 32'(e_done));
        chk($sformatf("d%0d_pass", i), 32'(pass_o[i]), 32'(e_pass));
        chk($sformatf("d%0d_mismatch_count", i), 32'(mc_o[i]), 32'(e_mc));
        chk($sformatf("d%0d_first_fail_valid", i), 32'(ffvalid_o[i]), 32'(e_ffvalid));
        chk($sformatf("d%0d_first_fail_vec", i), 32'(ffv_o[i]), 32'(e_ffv));
      end
    end
  end

  // Pulse start, then count cycles until each DUT shows done; optional start pulse mid-run.
  task automatic run(input int mid_start_at, output int t0, output int t1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = -1;
    t1 = -1;
    for (int n = 0; n <= 80; n++) begin
      if (t0 < 0 && done_o[0]) t0 = n;
      if (t1 < 0 && done_o[1]) t1 = n;
      if (t0 >= 0 && t1 >= 0) break;
      start = (n == mid_start_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  int t0, t1;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mask = 8'h00; chk_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_d%0d_vec", i), 32'(vec_o[i]), 0);
      chk($sformatf("rst_d%0d_busy", i), 32'(busy_o[i]), 0);
      chk($sformatf("rst_d%0d_done", i), 32'(done_o[i]), 0);
    end
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // All implementations agree.
    run(-1, t0, t1);
    chk("A_done_lat_s1", 32'(t0), 16);
    chk("A_done_lat_s3", 32'(t1), 32);
    chk("A_pass", 32'(pass_o[0]), 1);
    chk("A_mc", 32'(mc_o[0]), 0);
    chk("A_ffvalid", 32'(ffvalid_o[0]), 0);
    chk("A_last_vec", 32'(vec_o[0]), 7);

    // Single disagreement at vector 5.
    mask = 8'b0010_0000;
    run(-1, t0, t1);
    chk("B_done_lat_s1", 32'(t0), 16);
    chk("B_mc", 32'(mc_o[0]), 1);
    chk("B_ffv", 32'(ffv_o[0]), 5);
    chk("B_ffvalid", 32'(ffvalid_o[0]), 1);
    chk("B_pass", 32'(pass_o[0]), 0);

    // Disagreements at 2 and 6, start pulsed mid-run.
    mask = 8'b0100_0100;
    run(10, t0, t1);
    chk("C_done_lat_s1", 32'(t0), 16);
    chk("C_done_lat_s3", 32'(t1), 32);
    chk("C_mc_s3", 32'(mc_o[1]), 2);
    chk("C_ffv_s3", 32'(ffv_o[1]), 2);
    chk("C_pass_s3", 32'(pass_o[1]), 0);

    // Restart from a failed DONE with agreeing outputs.
    mask = 8'h00;
    run(-1, t0, t1);
    chk("D_pass_s1", 32'(pass_o[0]), 1);
    chk("D_pass_s3", 32'(pass_o[1]), 1);
    chk("D_ffvalid_s3", 32'(ffvalid_o[1]), 0);

    // Abort while the SETTLE=1 unit is applying vector 3.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("E_pre_vec", 32'(vec_o[0]), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("E_busy", 32'(busy_o[0]), 0);
    chk("E_vv", 32'(vv_o[0]), 0);
    chk("E_vec", 32'(vec_o[0]), 0);
    chk("E_done", 32'(done_o[0]), 0);
    run(-1, t0, t1);
    chk("E_done_lat_s3", 32'(t1), 32);
    chk("E_pass_s1", 32'(pass_o[0]), 1);

    // Reset mid-run after one mismatch has been counted.
    mask = 8'b0000_0100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("F_pre_vec", 32'(vec_o[0]), 4);
    chk("F_pre_mc", 32'(mc_o[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("F_vec", 32'(vec_o[0]), 0);
    chk("F_mc", 32'(mc_o[0]), 0);
    chk("F_ffvalid", 32'(ffvalid_o[0]), 0);
    chk("F_busy", 32'(busy_o[0]), 0);
    run(-1, t0, t1);
    chk("F_done_lat_s1", 32'(t0), 16);
    chk("F_mc_after", 32'(mc_o[0]), 1);
    chk("F_ffv_after", 32'(ffv_o[1]), 2);

    // start and abort together in DONE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("G_done", 32'(done_o[0]), 0);
    chk("G_busy", 32'(busy_o[1]), 0);
    chk("G_mc", 32'(mc_o[0]), 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
